tone_arbiter: RTL and testbench



---
 rtl/audio_pkg.sv | 30 +++
 rtl/tone_arbiter_if.sv | 30 +++
 rtl/tone_gen.sv | 49 ++++
 rtl/tone_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tone_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the tone arbiter and its square-wave generator.
// Contents: FSM state enum, reference amplitudes, default clock/tick rates and
// sizing helpers used by tone_arbiter, tone_arbiter_if and tone_gen.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [11:0] AMP_FULL = 12'h800;
    localparam logic [11:0] AMP_HALF = 12'h400;

    localparam int unsigned CLK_HZ_DEF       = 100_000_000;
    localparam int unsigned TICK_HZ_DEF      = 1000;
    localparam int unsigned TICKS_PER_MS_DEF = CLK_HZ_DEF / TICK_HZ_DEF;

    // Clocks per duration tick; never below one so the prescaler stays sane.
    function automatic int unsigned ticks_per_ms(input int unsigned clk_hz,
                                                 input int unsigned tick_hz);
        return (clk_hz / tick_hz == 0) ? 1 : clk_hz / tick_hz;
    endfunction

    // Width of a requester index; at least one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_arbiter_if.sv
// Requester-side bus of the tone arbiter.
// master: requesters (drive req/half_period/dur_ms/amp, observe ack/done/busy/
//         active_id/audio_sample); slave: the arbiter itself.
interface tone_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned HP_W    = 20
);
    localparam int unsigned ID_W = audio_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*HP_W-1:0] half_period;
    logic [NUM_REQ*12-1:0]   dur_ms;
    logic [NUM_REQ*12-1:0]   amp;
    logic [NUM_REQ-1:0]      ack;
    logic [NUM_REQ-1:0]      done;
    logic                    busy;
    logic [ID_W-1:0]         active_id;
    logic [11:0]             audio_sample;

    modport master (
        output req, half_period, dur_ms, amp,
        input  ack, done, busy, active_id, audio_sample
    );

    modport slave (
        input  req, half_period, dur_ms, amp,
        output ack, done, busy, active_id, audio_sample
    );

endinterface

// File: rtl/tone_gen.sv
// Square-wave generator for the granted tone job.
// Ports: clock, reset_n (async active-low), i_enable (playing), i_start (load a
// new job: output goes high immediately), i_half_period (clocks per level,
// 0 treated as 1), i_amp (high level), o_sample (registered DAC sample).
module tone_gen #(
    parameter int unsigned HP_W = 20
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_enable,
    input  logic            i_start,
    input  logic [HP_W-1:0] i_half_period,
    input  logic [11:0]     i_amp,
    output logic [11:0]     o_sample
);

    logic [HP_W-1:0] r_cnt;
    logic            r_high;
    logic [11:0]     r_sample;
    logic [HP_W-1:0] w_hp_eff;

    assign w_hp_eff = (i_half_period == '0) ? HP_W'(1) : i_half_period;

    // Level toggles after w_hp_eff enabled clocks; counter restarts at each toggle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_high   <= 1'b0;
            r_sample <= '0;
        end else if (!i_enable) begin
            r_cnt    <= '0;
            r_high   <= 1'b0;
            r_sample <= '0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_high   <= 1'b1;
            r_sample <= i_amp;
        end else if (r_cnt == w_hp_eff - HP_W'(1)) begin
            r_cnt    <= '0;
            r_high   <= ~r_high;
            r_sample <= r_high ? 12'h000 : i_amp;
        end else begin
            r_cnt    <= r_cnt + HP_W'(1);
        end
    end

    assign o_sample = r_sample;

endmodule

// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one audio DAC channel between NUM_REQ tone
// requesters. Latches pending jobs, grants the lowest pending index, plays its
// square wave for dur_ms ticks and then holds a GAP_MS-tick silent gap.
// Ports: clock, reset_n (async active-low), bus (tone_arbiter_if.slave:
// req/half_period/dur_ms/amp in; ack/done/busy/active_id/audio_sample out).
// Optional: define TONE_ARBITER_PREEMPT_EN to let a higher-priority pending
// request preempt a job in PLAY or GAP.
module tone_arbiter
    import audio_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ = TICK_HZ_DEF,
    parameter int unsigned GAP_MS  = 20,
    parameter int unsigned HP_W    = 20
) (
    input  logic           clock,
    input  logic           reset_n,
    tone_arbiter_if.slave  bus
);

    localparam int unsigned ID_W   = id_width(NUM_REQ);
    localparam int unsigned TPM    = ticks_per_ms(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W  = (TPM > 1) ? $clog2(TPM) : 1;
    localparam int unsigned TICK_W = 16;
    localparam int unsigned DUR_W  = 12;
    localparam int unsigned AMP_W  = 12;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_pending, r_ack, r_done, w_gmask;
    logic               r_busy;
    logic [ID_W-1:0]    r_active, w_gidx;
    logic [HP_W-1:0]    r_hp, w_hp_sel;
    logic [DUR_W-1:0]   r_dur;
    logic [AMP_W-1:0]   r_amp, w_amp_sel;
    logic [PRE_W-1:0]   r_pre;
    logic [TICK_W-1:0]  r_tick;
    logic               w_any, w_grant, w_done;
    logic               w_tick_wrap, w_play_end, w_gap_end, w_cnt_clr;
    logic [11:0]        w_sample;

    // Lowest set pending index wins.
    always_comb begin
        w_gidx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (r_pending[i]) w_gidx = ID_W'(i);
        end
    end

    assign w_any       = |r_pending;
    assign w_tick_wrap = (r_pre == PRE_W'(TPM - 1));
    assign w_play_end  = (r_dur == '0) ||
                         (w_tick_wrap && ((r_tick + TICK_W'(1)) >= TICK_W'(r_dur)));
    assign w_gap_end   = (GAP_MS == 0) ||
                         (w_tick_wrap && ((32'(r_tick) + 32'd1) >= GAP_MS));

    // Next state, grant and done decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (w_play_end) begin
                    w_done      = 1'b1;
                    // A zero-length job skips the silent gap.
                    w_state_nxt = (r_dur == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (w_gap_end) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
`ifdef TONE_ARBITER_PREEMPT_EN
        // A job already in GAP has issued its done; only a playing job gets one here.
        if ((r_state != IDLE) && w_any && (w_gidx < r_active)) begin
            w_grant     = 1'b1;
            w_done      = (r_state == PLAY);
            w_state_nxt = PLAY;
        end
`endif
    end

    assign w_gmask   = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
    assign w_cnt_clr = w_grant || (w_state_nxt != r_state);
    assign w_hp_sel  = w_grant ? bus.half_period[HP_W*32'(w_gidx) +: HP_W] : r_hp;
    assign w_amp_sel = w_grant ? bus.amp[AMP_W*32'(w_gidx) +: AMP_W] : r_amp;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Pending set, handshake pulses, latched job parameters and tick prescaler.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_active  <= '0;
            r_hp      <= '0;
            r_dur     <= '0;
            r_amp     <= '0;
            r_pre     <= '0;
            r_tick    <= '0;
        end else begin
            // A req on the grant edge re-arms the same index for a replay.
            r_pending <= (r_pending & ~w_gmask) | bus.req;
            r_ack     <= w_gmask;
            r_done    <= w_done ? (NUM_REQ'(1) << r_active) : '0;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_grant) begin
                r_active <= w_gidx;
                r_hp     <= w_hp_sel;
                r_dur    <= bus.dur_ms[DUR_W*32'(w_gidx) +: DUR_W];
                r_amp    <= w_amp_sel;
            end
            if (w_cnt_clr) begin
                r_pre  <= '0;
                r_tick <= '0;
            end else if (r_state != IDLE) begin
                if (w_tick_wrap) begin
                    r_pre <= '0;
                    if (r_tick != '1) r_tick <= r_tick + TICK_W'(1);
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

    // Fed with next-cycle values so the first high level lands on the grant edge.
    tone_gen #(
        .HP_W (HP_W)
    ) u_tone_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_enable      (w_state_nxt == PLAY),
        .i_start       (w_grant),
        .i_half_period (w_hp_sel),
        .i_amp         (w_amp_sel),
        .o_sample      (w_sample)
    );

    assign bus.ack          = r_ack;
    assign bus.done         = r_done;
    assign bus.busy         = r_busy;
    assign bus.active_id    = r_active;
    assign bus.audio_sample = w_sample;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter with 100 clocks per ms and a 2 ms gap.
// A time-stamp model predicts every output each cycle; literal checks pin
// latencies, lengths and reset behaviour.
module tb_tone_arbiter;

    localparam int TPM = 100;
    localparam int GAP = 2;

    logic clk;
    logic rst_n;

    tone_arbiter_if #(.NUM_REQ(4), .HP_W(20)) bus ();

    tone_arbiter #(
        .NUM_REQ (4),
        .CLK_HZ  (100000),
        .TICK_HZ (1000),
        .GAP_MS  (GAP),
        .HP_W    (20)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int req_cyc = 0;
    int ack_count = 0;
    int mark = 0;
    int busy_fall = -1000;
    int ack_cyc[4] = '{-1000, -1000, -1000, -1000};
    int done_cyc[4] = '{-1000, -1000, -1000, -1000};
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 4;
    endfunction

    // Model: a job is described by its grant time and latched parameters;
    // outputs follow from the elapsed time since grant.
    logic [3:0]  m_pend = '0;
    logic        m_job = 1'b0;
    int          m_n = 0, m_t0 = 0, m_hp = 0, m_dur = 0;
    logic [11:0] m_amp = '0;
    logic [3:0]  e_ack = '0, e_done = '0;
    logic        e_busy = 1'b0;
    logic [1:0]  e_id = '0;
    logic [11:0] e_smp = '0;

    always @(posedge clk or negedge rst_n) begin
        int e, end_e, idle_e, hpe, g;
        logic grant_ok;
        if (!rst_n) begin
            m_pend = '0; m_job = 1'b0;
            e_ack = '0; e_done = '0; e_busy = 1'b0; e_id = '0; e_smp = '0;
        end else begin
            m_n++;
            e_ack = '0;
            e_done = '0;
            grant_ok = 1'b1;
            g = lowest(m_pend);
            if (m_job) begin
                e      = m_n - m_t0;
                end_e  = (m_dur == 0) ? 1 : m_dur * TPM;
                idle_e = (m_dur == 0) ? end_e : end_e + ((GAP == 0) ? 1 : GAP * TPM);
                hpe    = (m_hp == 0) ? 1 : m_hp;
                if (e == end_e) e_done = 4'(1) << e_id;
                e_busy = (e < idle_e);
                e_smp  = (e < end_e && ((e / hpe) % 2 == 0)) ? m_amp : 12'h000;
                grant_ok = (e > idle_e);
`ifdef TONE_ARBITER_PREEMPT_EN
                if (e <= idle_e && g < int'(e_id)) begin
                    grant_ok = 1'b1;
                    if (e <= end_e) e_done = 4'(1) << e_id;
                end
`endif
            end
            if (grant_ok && g < 4) begin
                m_pend[g] = 1'b0;
                m_job  = 1'b1;
                m_t0   = m_n;
                m_hp   = int'(bus.half_period[g*20 +: 20]);
                m_dur  = int'(bus.dur_ms[g*12 +: 12]);
                m_amp  = bus.amp[g*12 +: 12];
                e_ack  = 4'(1) << g;
                e_id   = 2'(g);
                e_busy = 1'b1;
                e_smp  = m_amp;
            end
            m_pend = m_pend | bus.req;
        end
    end

    // Per-cycle compare plus event time stamps for the literal checks.
    always @(posedge clk) begin
        #1;
        cyc++;
        check("ack", 32'(bus.ack), 32'(e_ack));
        check("done", 32'(bus.done), 32'(e_done));
        check("busy", 32'(bus.busy), 32'(e_busy));
        if (e_busy) check("active_id", 32'(bus.active_id), 32'(e_id));
        check("audio_sample", 32'(bus.audio_sample), 32'(e_smp));
        for (int i = 0; i < 4; i++) begin
            if (bus.ack[i])  ack_cyc[i]  = cyc;
            if (bus.done[i]) done_cyc[i] = cyc;
        end
        if (bus.ack != 4'b0) ack_count++;
        if (prev_busy && !bus.busy) busy_fall = cyc;
        prev_busy = bus.busy;
    end

    task automatic set_job(input int idx, input int hp, input int dur, input int amp);
        bus.half_period[idx*20 +: 20] = 20'(hp);
        bus.dur_ms[idx*12 +: 12]      = 12'(dur);
        bus.amp[idx*12 +: 12]         = 12'(amp);
    endtask

    task automatic pulse(input int idx);
        bus.req[idx] = 1'b1;
        req_cyc = cyc + 1;
        @(negedge clk);
        bus.req = '0;
    endtask

    initial begin
        bus.req = '0; bus.half_period = '0; bus.dur_ms = '0; bus.amp = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sample", 32'(bus.audio_sample), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_active_id", 32'(bus.active_id), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single job, hp=10, 3 ms
        set_job(1, 10, 3, 'h800);
        pulse(1);
        @(negedge clk);
        check("t1_ack_vector", 32'(bus.ack), 32'h2);
        check("t1_first_high", 32'(bus.audio_sample), 32'h800);
        repeat (12) @(negedge clk);
        check("t1_second_half_low", 32'(bus.audio_sample), 32'h0);
        repeat (520) @(negedge clk);
        check("t1_ack_latency", 32'(ack_cyc[1] - req_cyc), 32'd1);
        check("t1_play_len", 32'(done_cyc[1] - ack_cyc[1]), 32'd300);
        check("t1_gap_len", 32'(busy_fall - done_cyc[1]), 32'd200);

        // 2: simultaneous req[2] and req[0]
        set_job(0, 5, 1, 'h400);
        set_job(2, 7, 1, 'h123);
        mark = ack_count;
        bus.req = 4'b0101;
        req_cyc = cyc + 1;
        @(negedge clk);
        bus.req = '0;
        repeat (640) @(negedge clk);
        check("t2_first_grant_0", 32'(ack_cyc[0] - req_cyc), 32'd1);
        check("t2_second_after_gap", 32'(ack_cyc[2] - done_cyc[0]), 32'd201);
        check("t2_grant_count", 32'(ack_count - mark), 32'd2);

        // 3: zero duration
        set_job(3, 4, 0, 0);
        pulse(3);
        repeat (10) @(negedge clk);
        check("t3_done_next_edge", 32'(done_cyc[3] - ack_cyc[3]), 32'd1);
        check("t3_busy_one_cycle", 32'(busy_fall - ack_cyc[3]), 32'd1);

        // 4: hp=0 toggles every clock; mid-job hp change ignored
        set_job(1, 0, 1, 'h800);
        pulse(1);
        @(negedge clk);
        check("t4_first_high", 32'(bus.audio_sample), 32'h800);
        @(negedge clk);
        check("t4_toggle_each_clk", 32'(bus.audio_sample), 32'h0);
        set_job(1, 50, 1, 'h800);
        repeat (340) @(negedge clk);
        check("t4_play_len", 32'(done_cyc[1] - ack_cyc[1]), 32'd100);

        // 5: reset mid-PLAY with req[2] pending
        set_job(1, 10, 5, 'h800);
        pulse(1);
        repeat (20) @(negedge clk);
        set_job(2, 6, 1, 'h300);
        pulse(2);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_busy", 32'(bus.busy), 32'd0);
        check("t5_async_sample", 32'(bus.audio_sample), 32'd0);
        check("t5_async_ack_done", 32'({bus.ack, bus.done}), 32'd0);
        check("t5_async_active_id", 32'(bus.active_id), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mark = ack_count;
        repeat (400) @(negedge clk);
        check("t5_no_ack_after_reset", 32'(ack_count - mark), 32'd0);
        set_job(0, 4, 1, 'h200);
        pulse(0);
        repeat (330) @(negedge clk);
        check("t5_recover_latency", 32'(ack_cyc[0] - req_cyc), 32'd1);

        // 6: req[0] during req[3] PLAY
        set_job(3, 8, 2, 'h400);
        pulse(3);
        repeat (31) @(negedge clk);
        set_job(0, 3, 1, 'h7ff);
        pulse(0);
        repeat (740) @(negedge clk);
`ifdef TONE_ARBITER_PREEMPT_EN
        check("t6_preempt_same_cycle", 32'(ack_cyc[0] - done_cyc[3]), 32'd0);
`else
        check("t6_waits_for_gap", 32'(ack_cyc[0] - done_cyc[3]), 32'd201);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
